// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI master and slave: word/byte geometry, the
// slave FSM state type, and a helper that selects one bit of a word
// addressed by {byte index, bit index}.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_WORD_W         = 32;
    localparam int SPI_BYTE_W         = 8;
    localparam int SPI_BYTES_PER_WORD = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        SELECT = 1'b1
    } spi_state_e;

    // Bit 8*idx + bit_pos of a word; {idx, bit_pos} is exactly that index.
    function automatic logic word_bit(input logic [SPI_WORD_W-1:0] word,
                                      input logic [1:0]            idx,
                                      input logic [2:0]            bit_pos);
        word_bit = word[{idx, bit_pos}];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// N-stage synchronizer for an asynchronous input, followed by a registered
// edge detector.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   din          : asynchronous input
//   rise, fall   : one-cycle pulses on a synchronized rising/falling edge
// Parameters:
//   STAGES       : synchronizer depth (2 or 3)
//   INIT         : idle level of din; the chain resets to it so that
//                  leaving reset does not fabricate an edge
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Synchronizer chain and registered edge detection on its last stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain_r <= {STAGES{INIT}};
            prev_r  <= INIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], din};
            prev_r  <= chain_r[STAGES-1];
            rise_r  <= chain_r[STAGES-1] & ~prev_r;
            fall_r  <= ~chain_r[STAGES-1] & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/spi_slave_core.sv
// ---------------------------------------------------------------------------
// spi_slave_core
// SPI mode-0 (CPOL=0, CPHA=0) LSB-first responder. A 32-bit word travels as
// four 8-bit slave-select frames, byte [7:0] first. All SPI inputs are
// oversampled in the clk domain.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   sclk, ss_n, mosi  : asynchronous SPI inputs from the master
//   miso, miso_oe     : registered slave data out and its output enable
//   tx_data, tx_load  : next reply word and its one-cycle capture strobe
//   resync            : forces the byte index to 0, drops any partial word
//   rx_data, rx_valid : last complete received word and its update pulse
//   tx_underrun       : pulse, a word started with no fresh reply loaded
//   frame_err         : pulse, ss_n rose in the middle of a byte
// ---------------------------------------------------------------------------
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SPI_WORD_W-1:0] tx_data,
    input  logic                  tx_load,
    input  logic                  resync,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err
);

    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   ss_rise_s;
    logic                   ss_fall_s;
    logic [SYNC_STAGES-1:0] mosi_chain_r;
    logic                   mosi_s;

    spi_state_e             state_r;
    logic [2:0]             bit_cnt_r;
    logic [1:0]             byte_idx_r;
    logic [SPI_BYTE_W-2:0]  rx_shift_r;   // bit 7 comes straight from mosi
    logic [23:0]            rx_word_r;    // bytes 0..2; byte 3 goes to rx_data
    logic [SPI_BYTE_W-1:0]  rx_byte_s;
    logic [SPI_WORD_W-1:0]  rx_data_r;
    logic                   rx_valid_r;
    logic                   frame_err_r;
    logic                   miso_r;
    logic                   miso_oe_r;

    logic [SPI_WORD_W-1:0]  tx_word_r;
    logic [SPI_WORD_W-1:0]  pend_word_r;
    logic                   pend_valid_r;
    logic                   fresh_r;      // a reply was loaded since the last word started
    logic                   tx_underrun_r;

    logic                   active_rise_s;
    logic                   word_start_s;
    logic                   word_done_s;
    logic                   load_now_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sclk),
        .rise    (sclk_rise_s),
        .fall    (sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ss_n),
        .rise    (ss_rise_s),
        .fall    (ss_fall_s)
    );

    // Plain synchronizer of equal depth keeps mosi aligned with the sclk edge pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mosi_chain_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_chain_r <= {mosi_chain_r[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_chain_r[SYNC_STAGES-1];

    // A sampling edge that is acted on: selected, not cancelled by resync or
    // by a simultaneous end of frame.
    assign active_rise_s = !resync && (state_r == SELECT) && !ss_rise_s && sclk_rise_s;
    assign word_start_s  = active_rise_s && (byte_idx_r == 2'd0) && (bit_cnt_r == 3'd0);
    assign word_done_s   = active_rise_s && (byte_idx_r == 2'd3) && (bit_cnt_r == 3'd7);
    // A load coinciding with the first sampling edge is too late for this word.
    assign load_now_s    = tx_load && (byte_idx_r == 2'd0) && (bit_cnt_r == 3'd0) && !word_start_s;
    assign rx_byte_s     = {mosi_s, rx_shift_r};

    // Frame FSM, receive shifting, word assembly and miso drive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            byte_idx_r  <= 2'd0;
            rx_shift_r  <= 7'd0;
            rx_word_r   <= 24'd0;
            rx_data_r   <= 32'd0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            miso_r      <= 1'b0;
            miso_oe_r   <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (resync) begin
                state_r    <= IDLE;
                miso_oe_r  <= 1'b0;
                bit_cnt_r  <= 3'd0;
                byte_idx_r <= 2'd0;
                rx_shift_r <= 7'd0;
                rx_word_r  <= 24'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        // sclk edges are ignored here; only a new frame matters
                        if (ss_fall_s) begin
                            state_r   <= SELECT;
                            miso_oe_r <= 1'b1;
                            miso_r    <= word_bit(tx_word_r, byte_idx_r, bit_cnt_r);
                        end
                    end
                    SELECT: begin
                        if (ss_rise_s) begin
                            state_r   <= IDLE;
                            miso_oe_r <= 1'b0;
                            // a frame that ends mid-byte loses that byte only
                            if (bit_cnt_r != 3'd0) begin
                                bit_cnt_r   <= 3'd0;
                                rx_shift_r  <= 7'd0;
                                frame_err_r <= 1'b1;
                            end
                        end else if (sclk_rise_s) begin
                            if (bit_cnt_r == 3'd7) begin
                                bit_cnt_r  <= 3'd0;
                                rx_shift_r <= 7'd0;
                                byte_idx_r <= byte_idx_r + 2'd1;
                                case (byte_idx_r)
                                    2'd0: rx_word_r[7:0]   <= rx_byte_s;
                                    2'd1: rx_word_r[15:8]  <= rx_byte_s;
                                    2'd2: rx_word_r[23:16] <= rx_byte_s;
                                    2'd3: begin
                                        rx_data_r  <= {rx_byte_s, rx_word_r};
                                        rx_valid_r <= 1'b1;
                                        rx_word_r  <= 24'd0;
                                    end
                                    default: rx_word_r <= 24'd0;
                                endcase
                            end else begin
                                rx_shift_r[bit_cnt_r] <= mosi_s;
                                bit_cnt_r             <= bit_cnt_r + 3'd1;
                            end
                        end else if (sclk_fall_s) begin
                            miso_r <= word_bit(tx_word_r, byte_idx_r, bit_cnt_r);
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        miso_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Reply word buffering: direct load at a word boundary, otherwise
    // pending until the next word completes; underrun detection at word start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_word_r     <= 32'd0;
            pend_word_r   <= 32'd0;
            pend_valid_r  <= 1'b0;
            fresh_r       <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            tx_underrun_r <= word_start_s && !fresh_r;
            if (word_start_s) begin
                fresh_r <= 1'b0;
            end
            if (word_done_s) begin
                // a load on the completing edge is newer than anything pending
                if (tx_load) begin
                    tx_word_r    <= tx_data;
                    fresh_r      <= 1'b1;
                    pend_valid_r <= 1'b0;
                end else if (pend_valid_r) begin
                    tx_word_r    <= pend_word_r;
                    fresh_r      <= 1'b1;
                    pend_valid_r <= 1'b0;
                end
            end else if (load_now_s) begin
                tx_word_r    <= tx_data;
                fresh_r      <= 1'b1;
                pend_valid_r <= 1'b0;
            end else if (tx_load) begin
                pend_word_r  <= tx_data;
                pend_valid_r <= 1'b1;
            end
        end
    end

    assign miso        = miso_r;
    assign miso_oe     = miso_oe_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign tx_underrun = tx_underrun_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_spi_slave_core.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_core
// Directed bench for spi_slave_core: a table of whole-word transfers plus
// hand-written sequences for mid-word loading, aborted bytes, resync and
// reset in the middle of a byte.
// ---------------------------------------------------------------------------
module tb_spi_slave_core;

    localparam int HALF = 8;   // clk cycles per sclk phase

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [31:0] tx_data;
    logic        tx_load;
    logic        resync;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        tx_underrun;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int n_rxv  = 0;
    int n_und  = 0;
    int n_ferr = 0;

    spi_slave_core #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .resync      (resync),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Count cycles each pulse output is high, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid)    n_rxv++;
        if (tx_underrun) n_und++;
        if (frame_err)   n_ferr++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // One slave-select frame of n bits, LSB first; returns bits read on miso.
    task automatic send_bits(input logic [7:0] b, input int n,
                             output logic [7:0] got, output logic oe_ok);
        got   = 8'h00;
        oe_ok = 1'b1;
        ss_n  = 1'b0;
        for (int i = 0; i < n; i++) begin
            mosi = b[i];
            repeat (HALF) @(negedge clk);
            got[i] = miso;
            if (miso_oe !== 1'b1) oe_ok = 1'b0;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, output logic [31:0] got, output logic oe_ok);
        logic [7:0] g;
        logic       o;
        got   = 32'h0;
        oe_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_bits(w[8*k +: 8], 8, g, o);
            got[8*k +: 8] = g;
            oe_ok = oe_ok & o;
        end
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic        load_en;
        logic [31:0] load_val;
        logic [31:0] mosi_word;
        logic [31:0] exp_miso;
        int          exp_und;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic [31:0] got;
        logic [7:0]  g8;
        logic        oe_ok;
        int          rxv0, und0, ferr0;

        // stimulus table: rx expectation is the word the master sends
        vecs[0] = '{1'b1, 32'hA1B2C3D4, 32'h11223344, 32'hA1B2C3D4, 0};
        vecs[1] = '{1'b0, 32'h00000000, 32'h0F0F0F0F, 32'hA1B2C3D4, 1};
        vecs[2] = '{1'b1, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 0};

        reset_n = 1'b0;
        sclk    = 1'b0;
        ss_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = 32'h0;
        tx_load = 1'b0;
        resync  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_miso",      {31'd0, miso},        32'd0);
        chk("reset_miso_oe",   {31'd0, miso_oe},     32'd0);
        chk("reset_rx_data",   rx_data,              32'd0);
        chk("reset_rx_valid",  {31'd0, rx_valid},    32'd0);
        chk("reset_underrun",  {31'd0, tx_underrun}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err},   32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // table-driven whole words
        for (int i = 0; i < 3; i++) begin
            rxv0 = n_rxv;
            und0 = n_und;
            if (vecs[i].load_en) do_load(vecs[i].load_val);
            send_word(vecs[i].mosi_word, got, oe_ok);
            chk($sformatf("vec%0d_rx_data", i),  rx_data, vecs[i].mosi_word);
            chk($sformatf("vec%0d_miso", i),     got,     vecs[i].exp_miso);
            chk($sformatf("vec%0d_oe", i),       {31'd0, oe_ok}, 32'd1);
            chk($sformatf("vec%0d_rx_valid", i), n_rxv - rxv0, 32'd1);
            chk($sformatf("vec%0d_underrun", i), n_und - und0, vecs[i].exp_und);
        end

        // reply loaded mid-word goes pending and becomes the next word
        do_load(32'h01020304);
        und0 = n_und;
        got  = 32'h0;
        for (int k = 0; k < 2; k++) begin
            send_bits(8'h0D - 8'(k), 8, g8, oe_ok);
            got[8*k +: 8] = g8;
        end
        do_load(32'h55AA00FF);
        for (int k = 2; k < 4; k++) begin
            send_bits(8'h0D - 8'(k), 8, g8, oe_ok);
            got[8*k +: 8] = g8;
        end
        repeat (4) @(negedge clk);
        chk("midload_w1_miso", got, 32'h01020304);
        chk("midload_w1_rx",   rx_data, 32'h0A0B0C0D);
        send_word(32'h11111111, got, oe_ok);
        chk("midload_w2_miso",     got, 32'h55AA00FF);
        chk("midload_no_underrun", n_und - und0, 32'd0);

        // frame aborted after 5 bits of byte 1
        do_load(32'hCAFE0001);
        rxv0 = n_rxv;
        send_bits(8'hEF, 8, g8, oe_ok);
        ferr0 = n_ferr;
        send_bits(8'h5A, 5, g8, oe_ok);
        chk("abort_frame_err", n_ferr - ferr0, 32'd1);
        chk("abort_no_word",   n_rxv - rxv0,   32'd0);
        send_bits(8'hCD, 8, g8, oe_ok);
        send_bits(8'hAB, 8, g8, oe_ok);
        send_bits(8'h89, 8, g8, oe_ok);
        repeat (4) @(negedge clk);
        chk("abort_rx_data",  rx_data,        32'h89ABCDEF);
        chk("abort_rx_valid", n_rxv - rxv0,   32'd1);
        chk("abort_single",   n_ferr - ferr0, 32'd1);

        // resync after two bytes drops the partial word
        rxv0 = n_rxv;
        send_bits(8'h77, 8, g8, oe_ok);
        send_bits(8'h66, 8, g8, oe_ok);
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        repeat (4) @(negedge clk);
        send_word(32'hDEADBEEF, got, oe_ok);
        chk("resync_rx_data",  rx_data,      32'hDEADBEEF);
        chk("resync_rx_valid", n_rxv - rxv0, 32'd1);

        // reset for one cycle in the middle of a byte
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_miso",      {31'd0, miso},        32'd0);
        chk("midrst_miso_oe",   {31'd0, miso_oe},     32'd0);
        chk("midrst_rx_data",   rx_data,              32'd0);
        chk("midrst_rx_valid",  {31'd0, rx_valid},    32'd0);
        chk("midrst_underrun",  {31'd0, tx_underrun}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err},   32'd0);
        reset_n = 1'b1;
        ss_n    = 1'b1;
        mosi    = 1'b0;
        repeat (2*HALF) @(negedge clk);
        // no load after reset: zeros go out with an underrun
        rxv0 = n_rxv;
        und0 = n_und;
        send_word(32'h0BADF00D, got, oe_ok);
        chk("postrst_rx_data",  rx_data,      32'h0BADF00D);
        chk("postrst_miso",     got,          32'h00000000);
        chk("postrst_underrun", n_und - und0, 32'd1);
        chk("postrst_rx_valid", n_rxv - rxv0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
